// File: rtl/branch_checkpoint_stack_pkg.sv
// Shared sizing, types and helpers for the branch checkpoint stack.
// The optional statistics counters are enabled with BRSTACK_STATS_EN.
package branch_checkpoint_stack_pkg;

    localparam int BR_DEPTH = 4;
    localparam int BR_TAG_W = 2;
    localparam int FL_IDX_W = 5;
    localparam int STAT_W   = 16;

    typedef logic [BR_TAG_W-1:0] br_tag_t;
    typedef logic [FL_IDX_W-1:0] fl_idx_t;
    typedef logic [BR_DEPTH-1:0] br_mask_t;
    typedef logic [STAT_W-1:0]   stat_cnt_t;

    // Everything the freelist sees on a recovery, registered together.
    typedef struct packed {
        logic     en;
        fl_idx_t  head;
        br_mask_t squash;
    } recov_t;

    function automatic br_tag_t tag_incr(input br_tag_t tag);
        return tag + br_tag_t'(1);
    endfunction

    function automatic stat_cnt_t sat_incr(input stat_cnt_t cnt);
        return (cnt == '1) ? cnt : cnt + stat_cnt_t'(1);
    endfunction

endpackage

// File: rtl/branch_checkpoint_stack_kill_gen.sv
// Circular kill mask: bits tag..tail-1 inclusive of tag. tag == tail means the
// stack is full (a mispredicting tag is always live), so every entry is killed.
module br_kill_mask_gen #(
    parameter int BR_DEPTH = 4,
    parameter int BR_TAG_W = 2
) (
    input  logic [BR_TAG_W-1:0] tag,
    input  logic [BR_TAG_W-1:0] tail,
    output logic [BR_DEPTH-1:0] kill_mask
);

    logic [BR_TAG_W:0] span;

    always_comb begin
        span = {1'b0, tail - tag};
        if (tail == tag) begin
            span = (BR_TAG_W+1)'(BR_DEPTH);
        end
        kill_mask = '0;
        for (int i = 0; i < BR_DEPTH; i++) begin
            kill_mask[i] = ({1'b0, BR_TAG_W'(i) - tag} < span);
        end
    end

endmodule

// File: rtl/branch_checkpoint_stack.sv
// Branch checkpoint stack: snapshots the freelist head per dispatched branch and
// restores it on mispredict. Define BRSTACK_STATS_EN for mispredict/stall counters.
module branch_checkpoint_stack
    import branch_checkpoint_stack_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                id_br_validA,
    input  logic                id_br_validB,
    input  logic                id_allocA,
    input  logic [FL_IDX_W-1:0] fl_head,
    input  logic [FL_IDX_W-1:0] fl_head_add_one,
    input  logic                ex_br_resolve_en,
    input  logic [BR_TAG_W-1:0] ex_br_tag,
    input  logic                ex_br_mispredict,
    output logic [BR_TAG_W-1:0] br_tag_out,
    output logic                br_stall,
    output logic                branch_recovery_en,
    output logic [FL_IDX_W-1:0] branch_recovery_head,
    output logic [BR_DEPTH-1:0] br_squash_mask
`ifdef BRSTACK_STATS_EN
    ,output logic [STAT_W-1:0]  br_mispredict_cnt
    ,output logic [STAT_W-1:0]  br_stall_cnt
`endif
);

    // Dispatch handshake: id_br_valid* is the request and ~br_stall the ready;
    // a branch is taken only when requested, not stalled, and no mispredict is
    // being accepted or recovered this cycle. ID must hold off while br_stall=1.
    br_mask_t                valid_q, valid_d;
    fl_idx_t [BR_DEPTH-1:0]  snap_q, snap_d;
    br_tag_t                 tail_q, tail_d;
    logic                    recov_q, recov_d;
    recov_t                  out_q, out_d;

    logic     br_req;
    logic     tag_valid;
    logic     resolve_ok;
    logic     mispredict_now;
    logic     br_dispatch;
    fl_idx_t  snap_sel;
    br_mask_t kill_mask;

    br_kill_mask_gen #(
        .BR_DEPTH (BR_DEPTH),
        .BR_TAG_W (BR_TAG_W)
    ) u_kill_gen (
        .tag       (ex_br_tag),
        .tail      (tail_q),
        .kill_mask (kill_mask)
    );

    assign br_req         = id_br_validA | id_br_validB;
    assign br_stall       = valid_q[tail_q];
    assign br_tag_out     = tail_q;
    assign tag_valid      = valid_q[ex_br_tag];
    assign resolve_ok     = ex_br_resolve_en & ~ex_br_mispredict & tag_valid;
    assign mispredict_now = ex_br_resolve_en & ex_br_mispredict & tag_valid;
    assign br_dispatch    = br_req & ~br_stall & ~recov_q & ~mispredict_now;

    // A lone slot-B branch behind an allocating slot A must skip A's tag.
    assign snap_sel = (id_br_validB & ~id_br_validA & id_allocA) ? fl_head_add_one : fl_head;

    always_comb begin
        valid_d    = valid_q;
        snap_d     = snap_q;
        tail_d     = tail_q;
        recov_d    = 1'b0;
        out_d      = out_q;
        out_d.en   = 1'b0;

        if (resolve_ok) begin
            valid_d[ex_br_tag] = 1'b0;
        end

        if (br_dispatch) begin
            valid_d[tail_q] = 1'b1;
            snap_d[tail_q]  = snap_sel;
            tail_d          = tag_incr(tail_q);
        end

        if (mispredict_now) begin
            valid_d      = valid_q & ~kill_mask;
            tail_d       = ex_br_tag;
            recov_d      = 1'b1;
            out_d.en     = 1'b1;
            out_d.head   = snap_q[ex_br_tag];
            out_d.squash = kill_mask;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            tail_q  <= '0;
            recov_q <= 1'b0;
            out_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tail_q  <= tail_d;
            recov_q <= recov_d;
            out_q   <= out_d;
        end
    end

    // Snapshot contents are only meaningful while the matching valid bit is set.
    always_ff @(posedge clock) begin
        snap_q <= snap_d;
    end

    assign branch_recovery_en   = out_q.en;
    assign branch_recovery_head = out_q.head;
    assign br_squash_mask       = out_q.squash;

`ifdef BRSTACK_STATS_EN
    stat_cnt_t mispredict_cnt_q, mispredict_cnt_d;
    stat_cnt_t stall_cnt_q, stall_cnt_d;

    always_comb begin
        mispredict_cnt_d = mispredict_cnt_q;
        stall_cnt_d      = stall_cnt_q;
        if (mispredict_now) begin
            mispredict_cnt_d = sat_incr(mispredict_cnt_q);
        end
        if (br_req & br_stall) begin
            stall_cnt_d = sat_incr(stall_cnt_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mispredict_cnt_q <= '0;
            stall_cnt_q      <= '0;
        end else begin
            mispredict_cnt_q <= mispredict_cnt_d;
            stall_cnt_q      <= stall_cnt_d;
        end
    end

    assign br_mispredict_cnt = mispredict_cnt_q;
    assign br_stall_cnt      = stall_cnt_q;
`else
    // Without statistics there is no extra state; the stack logic is unchanged.
`endif

endmodule

// File: tb/tb_branch_checkpoint_stack.sv
// Directed bench for branch_checkpoint_stack; recovery outputs are checked
// against an expected queue filled as each clock's stimulus is driven.
module tb_branch_checkpoint_stack;

    logic       clock;
    logic       reset;
    logic       id_br_validA;
    logic       id_br_validB;
    logic       id_allocA;
    logic [4:0] fl_head;
    logic [4:0] fl_head_add_one;
    logic       ex_br_resolve_en;
    logic [1:0] ex_br_tag;
    logic       ex_br_mispredict;
    logic [1:0] br_tag_out;
    logic       br_stall;
    logic       branch_recovery_en;
    logic [4:0] branch_recovery_head;
    logic [3:0] br_squash_mask;
`ifdef BRSTACK_STATS_EN
    logic [15:0] br_mispredict_cnt;
    logic [15:0] br_stall_cnt;
`endif

    // Expected word: [10] check head/mask, [9] recovery_en, [8:4] head, [3:0] mask.
    logic [10:0] exp_q[$];
    int n_assert;
    int n_fail;

    localparam logic [10:0] E_IDLE = 11'b0;
    localparam logic [10:0] E_ZERO = 11'b100_0000_0000;

    branch_checkpoint_stack dut (
        .clock                (clock),
        .reset                (reset),
        .id_br_validA         (id_br_validA),
        .id_br_validB         (id_br_validB),
        .id_allocA            (id_allocA),
        .fl_head              (fl_head),
        .fl_head_add_one      (fl_head_add_one),
        .ex_br_resolve_en     (ex_br_resolve_en),
        .ex_br_tag            (ex_br_tag),
        .ex_br_mispredict     (ex_br_mispredict),
        .br_tag_out           (br_tag_out),
        .br_stall             (br_stall),
        .branch_recovery_en   (branch_recovery_en),
        .branch_recovery_head (branch_recovery_head),
        .br_squash_mask       (br_squash_mask)
`ifdef BRSTACK_STATS_EN
        ,.br_mispredict_cnt   (br_mispredict_cnt)
        ,.br_stall_cnt        (br_stall_cnt)
`endif
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [10:0] e_rec(input logic [4:0] head, input logic [3:0] mask);
        return {1'b1, 1'b1, head, mask};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the word pushed is what the recovery regs must hold after it.
    task automatic tick(input logic [10:0] e);
        logic [10:0] x;
        exp_q.push_back(e);
        @(negedge clock);
        #1;
        x = exp_q.pop_front();
        check("recovery_en", 32'(branch_recovery_en), 32'(x[9]));
        if (x[10]) begin
            check("recovery_head", 32'(branch_recovery_head), 32'(x[8:4]));
            check("squash_mask", 32'(br_squash_mask), 32'(x[3:0]));
        end
    endtask

    // Driver tasks
    task automatic idle_in();
        id_br_validA     = 1'b0;
        id_br_validB     = 1'b0;
        id_allocA        = 1'b0;
        fl_head          = 5'd0;
        fl_head_add_one  = 5'd0;
        ex_br_resolve_en = 1'b0;
        ex_br_tag        = 2'd0;
        ex_br_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        tick(E_ZERO);
        tick(E_ZERO);
        reset = 1'b0;
    endtask

    task automatic dispatch(input logic a, input logic b, input logic alloc,
                            input logic [4:0] h, input logic [4:0] h1, input logic [1:0] exp_tag);
        idle_in();
        id_br_validA    = a;
        id_br_validB    = b;
        id_allocA       = alloc;
        fl_head         = h;
        fl_head_add_one = h1;
        #1;
        check("dispatch_tag", 32'(br_tag_out), 32'(exp_tag));
        check("dispatch_stall", 32'(br_stall), 32'd0);
        tick(E_IDLE);
        idle_in();
    endtask

    task automatic mispredict(input logic [1:0] tag, input logic [4:0] h, input logic [3:0] m);
        idle_in();
        ex_br_resolve_en = 1'b1;
        ex_br_tag        = tag;
        ex_br_mispredict = 1'b1;
        #1;
        tick(e_rec(h, m));
        idle_in();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        idle_in();
        do_reset();
        check("reset_tag", 32'(br_tag_out), 32'd0);
        check("reset_stall", 32'(br_stall), 32'd0);

        // Slot A branch snapshots fl_head; mispredict reveals it.
        dispatch(1'b1, 1'b0, 1'b0, 5'd7, 5'd8, 2'd0);
        check("tag_after_first", 32'(br_tag_out), 32'd1);
        mispredict(2'd0, 5'd7, 4'b0001);
        id_br_validA = 1'b1;
        fl_head      = 5'd3;
        #1;
        check("recov_tag", 32'(br_tag_out), 32'd0);
        tick(E_IDLE);
        idle_in();
        check("recov_dispatch_dropped", 32'(br_tag_out), 32'd0);
        check("recov_stall", 32'(br_stall), 32'd0);

        // Slot B behind allocating slot A takes head+1, including the wrap to 0.
        dispatch(1'b0, 1'b1, 1'b1, 5'd30, 5'd31, 2'd0);
        dispatch(1'b0, 1'b1, 1'b1, 5'd31, 5'd0, 2'd1);
        mispredict(2'd1, 5'd0, 4'b0010);
        tick(E_IDLE);
        mispredict(2'd0, 5'd31, 4'b0001);
        tick(E_IDLE);

        // Fill all four checkpoints; A wins over B; B without alloc uses fl_head.
        dispatch(1'b1, 1'b0, 1'b0, 5'd4, 5'd5, 2'd0);
        dispatch(1'b1, 1'b0, 1'b0, 5'd9, 5'd10, 2'd1);
        dispatch(1'b1, 1'b1, 1'b1, 5'd12, 5'd13, 2'd2);
        dispatch(1'b0, 1'b1, 1'b0, 5'd20, 5'd21, 2'd3);
        check("full_stall", 32'(br_stall), 32'd1);
        check("full_tag", 32'(br_tag_out), 32'd0);
        id_br_validA = 1'b1;
        fl_head      = 5'd25;
        #1;
        tick(E_IDLE);
        idle_in();
        ex_br_resolve_en = 1'b1;
        ex_br_tag        = 2'd1;
        #1;
        tick(E_IDLE);
        idle_in();
        check("stall_after_res1", 32'(br_stall), 32'd1);
        ex_br_resolve_en = 1'b1;
        ex_br_tag        = 2'd0;
        id_br_validA     = 1'b1;
        fl_head          = 5'd26;
        #1;
        check("stall_no_bypass", 32'(br_stall), 32'd1);
        tick(E_IDLE);
        idle_in();
        check("stall_after_res0", 32'(br_stall), 32'd0);
        check("tag_after_res0", 32'(br_tag_out), 32'd0);

        // Mispredict with a dispatch in the same cycle; kill set wraps 2..3.
        ex_br_resolve_en = 1'b1;
        ex_br_tag        = 2'd2;
        ex_br_mispredict = 1'b1;
        id_br_validA     = 1'b1;
        fl_head          = 5'd17;
        #1;
        tick(e_rec(5'd12, 4'b1100));
        idle_in();
        ex_br_resolve_en = 1'b1;
        ex_br_tag        = 2'd3;
        ex_br_mispredict = 1'b1;
        #1;
        tick(E_IDLE);
        idle_in();
        check("tail_after_mis2", 32'(br_tag_out), 32'd2);
        check("stall_after_mis2", 32'(br_stall), 32'd0);
        dispatch(1'b1, 1'b0, 1'b0, 5'd2, 5'd3, 2'd2);
        dispatch(1'b1, 1'b0, 1'b0, 5'd3, 5'd4, 2'd3);
        dispatch(1'b1, 1'b0, 1'b0, 5'd5, 5'd6, 2'd0);
        check("tag_after_refill", 32'(br_tag_out), 32'd1);
        mispredict(2'd3, 5'd3, 4'b1001);
        tick(E_IDLE);
`ifdef BRSTACK_STATS_EN
        check("mispredict_cnt_a", 32'(br_mispredict_cnt), 32'd5);
        check("stall_cnt_a", 32'(br_stall_cnt), 32'd2);
`endif

        // Tags 0,1,2 live with snaps 4,9,12; mispredict tag 1.
        do_reset();
        dispatch(1'b1, 1'b0, 1'b0, 5'd4, 5'd5, 2'd0);
        dispatch(1'b1, 1'b0, 1'b0, 5'd9, 5'd10, 2'd1);
        dispatch(1'b1, 1'b0, 1'b0, 5'd12, 5'd13, 2'd2);
        mispredict(2'd1, 5'd9, 4'b0110);
        tick(E_IDLE);
        check("tail_after_mis1", 32'(br_tag_out), 32'd1);

        // Full stack mispredict on the oldest kills everything; reset in the pulse cycle.
        dispatch(1'b1, 1'b0, 1'b0, 5'd5, 5'd6, 2'd1);
        dispatch(1'b1, 1'b0, 1'b0, 5'd6, 5'd7, 2'd2);
        dispatch(1'b1, 1'b0, 1'b0, 5'd8, 5'd9, 2'd3);
        check("full_stall_b", 32'(br_stall), 32'd1);
        mispredict(2'd0, 5'd4, 4'b1111);
        reset = 1'b1;
        tick(E_ZERO);
        reset = 1'b0;
        check("reset_mid_tag", 32'(br_tag_out), 32'd0);
        check("reset_mid_stall", 32'(br_stall), 32'd0);
`ifdef BRSTACK_STATS_EN
        check("mispredict_cnt_reset", 32'(br_mispredict_cnt), 32'd0);
`endif

        // Three back-to-back single-branch mispredicts.
        for (int k = 1; k <= 3; k++) begin
            dispatch(1'b1, 1'b0, 1'b0, 5'(k), 5'(k + 1), 2'd0);
            mispredict(2'd0, 5'(k), 4'b0001);
            tick(E_IDLE);
        end
        check("final_stall", 32'(br_stall), 32'd0);
`ifdef BRSTACK_STATS_EN
        check("mispredict_cnt_b", 32'(br_mispredict_cnt), 32'd3);
        check("stall_cnt_b", 32'(br_stall_cnt), 32'd0);
`endif

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
